macro_seq_layer3: RTL

Sequencer and readout collector for the Layer3 compute-in-memory macro bank. On `start` it drives the `enable`/`adc`/`chs_ps` controls of all MACRO_NUM macros through four `chs_ps` phases and captures the 4-bit ADC column outputs of each phase. It combines macro pairs, shift-accumulates the phases into 128 channel partial sums and hands them downstream with a valid/ready handshake. It is the consumer and control end of the macro array interface, sitting between the macro bank and the Layer3 post-processing stage.

---
 rtl/macro_seq_layer3.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/macro_seq_layer3.sv
// macro_seq_layer3: sequences the Layer3 CIM macro bank through four chs_ps phases,
// sums macro pairs (0,1)/(2,3) and shift-accumulates them into 128 channel partial sums.
// Ports: clk/rst; start/busy frame control; enable/adc/chs_ps broadcast macro controls;
// macro_dout ADC columns in; psum/psum_valid/psum_ready downstream handshake.
// A frame takes 4*(EN_CYC+ADC_CYC+1) cycles; psum is held in DONE until psum_ready.
module macro_seq_layer3 #(
    parameter int MACRO_NUM = 4,
    parameter int COLS      = 64,
    parameter int ADC_W     = 4,
    parameter int PSUM_W    = 10,
    parameter int EN_CYC    = 2,
    parameter int ADC_CYC   = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            enable,
    output logic                            adc,
    output logic [1:0]                      chs_ps,
    input  logic [MACRO_NUM*COLS*ADC_W-1:0] macro_dout,
    output logic [2*COLS*PSUM_W-1:0]        psum,
    output logic                            psum_valid,
    input  logic                            psum_ready
);

    localparam int CNT_MAX = (EN_CYC > ADC_CYC) ? EN_CYC : ADC_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] ADC_LAST = CNT_W'(ADC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN,
        S_CONV,
        S_CAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         p_q, p_d;
    logic               clear, capture;

    logic               busy_q, busy_d;
    logic               enable_q, enable_d;
    logic               adc_q, adc_d;
    logic [1:0]         chs_ps_q, chs_ps_d;
    logic               valid_q, valid_d;

    logic [PSUM_W-1:0]  acc_q [2*COLS];
    logic [PSUM_W-1:0]  acc_d [2*COLS];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        clear   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EN;
                    cnt_d   = '0;
                    p_d     = 2'd0;
                    clear   = 1'b1;
                end
            end
            S_EN: begin
                if (cnt_q == EN_LAST) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CONV: begin
                if (cnt_q == ADC_LAST) begin
                    state_d = S_CAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CAP: begin
                capture = 1'b1;
                cnt_d   = '0;
                if (p_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    p_d     = p_q + 2'd1;
                    state_d = S_EN;
                end
            end
            S_DONE: begin
                // start is deliberately ignored here; only IDLE launches a frame
                if (psum_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        enable_d = (state_d == S_EN) || (state_d == S_CONV) || (state_d == S_CAP);
        adc_d    = (state_d == S_CONV);
        chs_ps_d = enable_d ? p_d : 2'd0;
        valid_d  = (state_d == S_DONE);
    end

    // Pair sums are ADC_W+1 bits unsigned; phase weight applied as a left shift.
    // The accumulator wraps modulo 2^PSUM_W.
    always_comb begin
        logic [ADC_W:0] pair_lo;
        logic [ADC_W:0] pair_hi;
        pair_lo = '0;
        pair_hi = '0;
        for (int n = 0; n < 2*COLS; n++) begin
            acc_d[n] = acc_q[n];
        end
        for (int c = 0; c < COLS; c++) begin
            pair_lo = {1'b0, macro_dout[c*ADC_W +: ADC_W]}
                    + {1'b0, macro_dout[(COLS+c)*ADC_W +: ADC_W]};
            pair_hi = {1'b0, macro_dout[(2*COLS+c)*ADC_W +: ADC_W]}
                    + {1'b0, macro_dout[(3*COLS+c)*ADC_W +: ADC_W]};
            if (clear) begin
                acc_d[c]      = '0;
                acc_d[COLS+c] = '0;
            end else if (capture) begin
                acc_d[c]      = acc_q[c]      + (PSUM_W'(pair_lo) << p_q);
                acc_d[COLS+c] = acc_q[COLS+c] + (PSUM_W'(pair_hi) << p_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= 2'd0;
            busy_q   <= 1'b0;
            enable_q <= 1'b0;
            adc_q    <= 1'b0;
            chs_ps_q <= 2'd0;
            valid_q  <= 1'b0;
            for (int n = 0; n < 2*COLS; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            enable_q <= enable_d;
            adc_q    <= adc_d;
            chs_ps_q <= chs_ps_d;
            valid_q  <= valid_d;
            for (int n = 0; n < 2*COLS; n++) begin
                acc_q[n] <= acc_d[n];
            end
        end
    end

    assign busy       = busy_q;
    assign enable     = enable_q;
    assign adc        = adc_q;
    assign chs_ps     = chs_ps_q;
    assign psum_valid = valid_q;

    for (genvar g = 0; g < 2*COLS; g++) begin : g_psum
        assign psum[g*PSUM_W +: PSUM_W] = acc_q[g];
    end

endmodule
